// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive peripheral.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_rx_pkg;

    // Receiver FSM states.
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_STOP      = 3'd3,
        ST_WAIT_IDLE = 3'd4
    } state_t;

    // Word-aligned register addresses on the peripheral bus.
    localparam logic [31:0] ADDR_CTRL = 32'h0;
    localparam logic [31:0] ADDR_DATA = 32'h4;

    // Bit positions in the control/status register.
    localparam int STAT_NE     = 0;
    localparam int STAT_FERR   = 1;
    localparam int STAT_OVR    = 2;
    localparam int STAT_FULL   = 3;
    localparam int STAT_CNT_LO = 4;
    localparam int STAT_CNT_HI = 6;

endpackage

// File: rtl/module_uart_rx_fifo.sv
// Byte buffer for received characters: circular FIFO of DEPTH entries (DEPTH <= 7).
// Latency: a push is visible at head/count the cycle after the push edge.
// Backpressure: push while full is dropped unless a pop lands on the same edge.
//
// Ports: clk_i/rst_ni clock and async active-low reset; push/push_dat write side;
//        pop read side; head_dat current head (0 when empty); full, empty, count status.
module module_uart_rx_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       push,
    input  logic [7:0] push_dat,
    input  logic       pop,
    output logic [7:0] head_dat,
    output logic       full,
    output logic       empty,
    output logic [2:0] count
);

    localparam int            PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] LAST    = PW'(DEPTH - 1);
    localparam logic [2:0]    DEPTH_C = 3'(DEPTH);

    logic [7:0]    mem [2**PW];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    // Pointers wrap explicitly so non-power-of-two depths stay correct.
    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    assign full    = (count == DEPTH_C);
    assign empty   = (count == 3'd0);
    assign do_pop  = pop && !empty;
    // A pop on the same edge frees the slot, so a push into a full buffer still lands.
    assign do_push = push && (!full || do_pop);

    assign head_dat = empty ? 8'h00 : mem[rd_ptr];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= 3'd0;
        end else begin
            if (do_push) wr_ptr <= next_ptr(wr_ptr);
            if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: head_dat is masked while empty.
    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr] <= push_dat;
    end

endmodule

// File: rtl/module_uart_rx.sv
// UART 8N1 receiver with 16x oversampling and a polled register interface.
// Latency: byte visible on the bus 1 clock after the mid-stop-bit sample (~9.5 bit times after start edge).
// Backpressure: none on the line; a byte arriving with the buffer full is dropped and OVR is set.
//
// Ports: clk_i system clock; rst_ni async active-low reset; rx serial line (idle high, async);
//        we_proc_i write strobe; do_proc_i write data; addr_proc_i byte address (0x0 ctrl/status,
//        0x4 data); do_proc_o combinational read data.
// Build option: define UART_RX_FIFO_EN for a 4-entry FIFO, otherwise a single holding register.
module module_uart_rx
    import uart_rx_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 10_000_000,
    parameter int BAUD        = 9600,
    parameter int OSR         = 16
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        rx,
    input  logic        we_proc_i,
    input  logic [31:0] do_proc_i,
    input  logic [31:0] addr_proc_i,
    output logic [31:0] do_proc_o
);

`ifdef UART_RX_FIFO_EN
    localparam int FIFO_DEPTH = 4;
`else
    localparam int FIFO_DEPTH = 1;
`endif

    localparam int         DIV       = CLK_FREQ_HZ / (BAUD * OSR);
    localparam logic [15:0] DIV_LAST  = 16'(DIV - 1);
    localparam logic [3:0]  SAMP_MID  = 4'(OSR / 2 - 1);
    localparam logic [3:0]  SAMP_LAST = 4'(OSR - 1);

    logic        rx_meta;
    logic        rx_sync;
    logic [15:0] tick_cnt;
    logic        tick;
    state_t      state;
    logic [3:0]  samp_cnt;
    logic [2:0]  bit_cnt;
    logic [7:0]  shift_dat;
    logic        start_det;
    logic        stop_smp;
    logic        push_req;
    logic        ferr_set;
    logic        ovr_set;
    logic        wr_ctrl;
    logic        pop_req;
    logic        ferr;
    logic        ovr;
    logic [7:0]  head_dat;
    logic        fifo_full;
    logic        fifo_empty;
    logic [2:0]  fifo_count;
    logic        unused_wdat;

    assign unused_wdat = ^do_proc_i[31:3];

    // Two-flop synchroniser, reset to the idle line level so reset never looks like a start bit.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
        end
    end

    assign start_det = (state == ST_IDLE) && !rx_sync;
    assign tick      = (tick_cnt == DIV_LAST);

    // Free-running oversample tick; realigned to the start edge so sampling phase is deterministic.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tick_cnt <= 16'd0;
        end else if (start_det || tick) begin
            tick_cnt <= 16'd0;
        end else begin
            tick_cnt <= tick_cnt + 16'd1;
        end
    end

    assign stop_smp = (state == ST_STOP) && tick && (samp_cnt == SAMP_LAST);
    assign push_req = stop_smp && rx_sync;
    assign ferr_set = stop_smp && !rx_sync;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state     <= ST_IDLE;
            samp_cnt  <= 4'd0;
            bit_cnt   <= 3'd0;
            shift_dat <= 8'h00;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!rx_sync) begin
                        state    <= ST_START;
                        samp_cnt <= 4'd0;
                    end
                end
                ST_START: begin
                    if (tick) begin
                        if (samp_cnt == SAMP_MID) begin
                            // Mid start bit: a line back high means a glitch, not a frame.
                            samp_cnt <= 4'd0;
                            bit_cnt  <= 3'd0;
                            state    <= rx_sync ? ST_IDLE : ST_DATA;
                        end else begin
                            samp_cnt <= samp_cnt + 4'd1;
                        end
                    end
                end
                ST_DATA: begin
                    if (tick) begin
                        if (samp_cnt == SAMP_LAST) begin
                            samp_cnt  <= 4'd0;
                            shift_dat <= {rx_sync, shift_dat[7:1]};  // LSB arrives first
                            bit_cnt   <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) state <= ST_STOP;
                        end else begin
                            samp_cnt <= samp_cnt + 4'd1;
                        end
                    end
                end
                ST_STOP: begin
                    if (tick) begin
                        if (samp_cnt == SAMP_LAST) begin
                            samp_cnt <= 4'd0;
                            state    <= rx_sync ? ST_IDLE : ST_WAIT_IDLE;
                        end else begin
                            samp_cnt <= samp_cnt + 4'd1;
                        end
                    end
                end
                ST_WAIT_IDLE: begin
                    // Hold off through a break until the line returns high.
                    if (rx_sync) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign wr_ctrl = we_proc_i && (addr_proc_i == ADDR_CTRL);
    assign pop_req = wr_ctrl && do_proc_i[STAT_NE];
    // A pop on the same edge makes room, so that case is not an overrun.
    assign ovr_set = push_req && fifo_full && !pop_req;

    // Sticky flags; a new event beats a simultaneous clear.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ferr <= 1'b0;
            ovr  <= 1'b0;
        end else begin
            if (ferr_set)                          ferr <= 1'b1;
            else if (wr_ctrl && do_proc_i[STAT_FERR]) ferr <= 1'b0;
            if (ovr_set)                           ovr  <= 1'b1;
            else if (wr_ctrl && do_proc_i[STAT_OVR])  ovr  <= 1'b0;
        end
    end

    module_uart_rx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .push     (push_req),
        .push_dat (shift_dat),
        .pop      (pop_req),
        .head_dat (head_dat),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    always_comb begin
        do_proc_o = 32'h0;
        if (addr_proc_i == ADDR_CTRL) begin
            do_proc_o[STAT_NE]                  = !fifo_empty;
            do_proc_o[STAT_FERR]                = ferr;
            do_proc_o[STAT_OVR]                 = ovr;
            do_proc_o[STAT_FULL]                = fifo_full;
            do_proc_o[STAT_CNT_HI:STAT_CNT_LO]  = fifo_count;
        end else if (addr_proc_i == ADDR_DATA) begin
            do_proc_o = {24'h0, head_dat};
        end
    end

endmodule

// File: doc/module_uart_rx.md
# module_uart_rx

UART receive peripheral: the block downstream of `module_top_uart`'s `tx` line, deserialising 8N1 frames into bytes that the processor reads through the same word-addressed register bus. It sits beside the transmitter on the peripheral bus and shares its address and data conventions. It oversamples the line at 16x, validates the start and stop bits, and buffers received bytes for polled readout.

## Interface
- `CLK_FREQ_HZ`, 10_000_000, system clock frequency.
- `BAUD`, 9600, line rate.
- `OSR`, 16, oversampling ratio; tick divisor `DIV = CLK_FREQ_HZ/(BAUD*OSR)`, truncated (65 at defaults).
- `clk_i`  in  1  system clock; all logic on rising edge.
- `rst_ni`  in  1  asynchronous, active-low reset.
- `rx`  in  1  serial line, idle high, asynchronous to `clk_i`.
- `we_proc_i`  in  1  write strobe, one cycle per write.
- `do_proc_i`  in  32  write data.
- `addr_proc_i`  in  32  byte address; only 0x0 and 0x4 are decoded.
- `do_proc_o`  out  32  read data, combinational from `addr_proc_i`.

## Operation
- `rx` passes through a 2-flop synchroniser reset to 1. The FSM sees only the synchronised value.
- Tick generator: a counter 0..DIV-1 emits a one-cycle `tick` at wrap. It runs freely and restarts at 0 when leaving IDLE.
- FSM states: IDLE, START, DATA, STOP, WAIT_IDLE.
  - IDLE: a falling edge (sync rx = 0) moves to START with sample counter = 0.
  - START: at the 8th tick, rx = 0 moves to DATA; rx = 1 is a false start and returns to IDLE.
  - DATA: samples every 16 ticks, LSB first, into a shift register. Moves to STOP after bit 7.
  - STOP: samples after 16 ticks. rx = 1 pushes the byte and returns to IDLE. rx = 0 sets FERR, discards the byte, and moves to WAIT_IDLE.
  - WAIT_IDLE: returns to IDLE when rx = 1. This covers a break condition.
- Register 0x0, read: [0] NE (buffer not empty), [1] FERR (sticky), [2] OVR (sticky), [3] FULL, [6:4] count, rest 0.
- Register 0x0, write: [0] = 1 pops the head entry, and is ignored when empty. [1] = 1 clears FERR. [2] = 1 clears OVR. Other bits are ignored.
- Register 0x4, read: {24'b0, head byte}. Reads 0 when empty. Reading never pops. Writes to 0x4 are ignored.
- Any other address reads 0; writes to it are ignored.
- Push when FULL: OVR is set, the new byte is dropped, and stored data is unchanged.
- Pop and push in the same cycle while FULL: both take effect, count is unchanged, and no OVR is raised.
- A clear write in the same cycle as a new FERR or OVR event: set wins.

## Timing
- Reset values: `do_proc_o` reflects empty state, so 0 at 0x4 and 0 at 0x0. FSM is IDLE, buffer is empty, flags are 0, synchroniser holds 1.
- Synchroniser latency is 2 clocks. The stop-bit sample lands about 9.5 bit times after the falling edge.
- NE is visible on `do_proc_o` 1 clock after the stop-sample cycle.
- A pop write takes effect at the clock edge where `we_proc_i` = 1. The next head is visible the following cycle.
- Reset asserted mid-frame aborts the frame immediately. No partial byte is stored, and the buffer and flags are cleared.

## Configuration
- `UART_RX_FIFO_EN` defined: 4-entry circular FIFO with 2-bit read and write pointers that wrap modulo 4. Count field is 0..4.
- `UART_RX_FIFO_EN` undefined: single holding register. Count field is 0..1, and FULL equals NE.
- Register map, flag semantics and overrun rules are identical in both builds.

## Structure
- Package `uart_rx_pkg` holds:
  - `state_t` enum for the FSM states;
  - address constants `ADDR_CTRL` = 32'h0 and `ADDR_DATA` = 32'h4;
  - status bit-index constants.
- One sub-module, `module_uart_rx_fifo`, parameterised on depth. It provides push, pop, full, empty and count. It is instantiated in both builds, with depth 4 or depth 1.

## Test plan
- Reset, then idle line: read 0x0 gives 0, read 0x4 gives 0, and the FSM stays IDLE for 2 ms.
- Send 0x7B at 9600 baud (104.0 µs/bit): within 2 clocks of the stop sample, 0x0 reads 0x11 and 0x4 reads 0x7B. Write 0x0 = 1, then 0x0 reads 0.
- Send 4 bytes 0x01, 0x02, 0x03, 0x04 with no pops (FIFO build): 0x0 reads 0x49. A 5th byte 0xAA sets OVR, so 0x0 reads 0x4D. Pops return 0x01 to 0x04 in order.
- Frame with stop bit = 0: FERR is set, count is unchanged, and the FSM waits for the line to go high. Writing 0x0 = 2 clears FERR.
- 2 µs low glitch on `rx`: rejected as a false start. Nothing is stored and no flags are set.
- `rst_ni` pulsed low during DATA bit 4: all state is cleared. The next full frame 0x55 is received correctly.
